vc_buffer_bank: RTL
===================

// Module: vc_buffer_bank
// PURPOSE
//  Per-input-port virtual-channel buffer for the NoC router. Stores flits in NUM_VC
//  independent FIFOs, selected by the upstream VC id. Lets the switch allocator read
//  any VC's head flit, and returns one credit per dequeued flit to the upstream router.
//  Successor to the single-register VC stage: multi-entry depth, parametrised VC
//  count, occupancy status and credit flow control.
// PARAMETERS
//  FLIT_W  8  flit width in bits
//  NUM_VC  3  number of virtual channels, >=2 (VC NUM_VC-1 = local NI channel)
//  DEPTH   4  entries per VC, power of 2, >=2
//  Derived: VC_W = $clog2(NUM_VC), PTR_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1)
// PORTS
//  clk          in   1              rising-edge clock
//  rst          in   1              asynchronous, active-high reset
//  wr_en        in   1              flit present on wr_flit this cycle
//  wr_vc        in   VC_W           target VC of write
//  wr_flit      in   FLIT_W         incoming flit
//  rd_en        in   1              dequeue head of rd_vc this cycle
//  rd_vc        in   VC_W           VC being read / viewed
//  rd_flit      out  FLIT_W         head flit of rd_vc (first-word fall-through)
//  vc_nempty    out  NUM_VC         per-VC not-empty flags
//  vc_full      out  NUM_VC         per-VC full flags
//  vc_count     out  NUM_VC*CNT_W   per-VC occupancy, VC0 in LSBs
//  credit_ret   out  NUM_VC         one-cycle credit pulse per VC, registered
//  err_ovf      out  1              sticky: write dropped (full or bad VC id)
//  err_udf      out  1              sticky: read of empty VC or bad VC id ignored
// BEHAVIOUR
//  - Reset (async, rst=1): all pointers/counts=0, vc_nempty=0, vc_full=0,
//    credit_ret=0, err_ovf=0, err_udf=0, rd_flit=0. Storage contents are not reset.
//  - Write: on the clk edge with wr_en=1 and wr_vc<NUM_VC and the VC not full (or
//    full with a same-cycle accepted read of the same VC), store wr_flit at the tail
//    and advance the tail pointer modulo DEPTH.
//  - Read: rd_flit = head of rd_vc combinationally, 0 when that VC is empty or
//    rd_vc>=NUM_VC. A clk edge with rd_en=1 on a non-empty valid VC advances the
//    head pointer modulo DEPTH.
//  - Count: per VC, count += write_accepted - read_accepted; range 0..DEPTH.
//    nempty = (count!=0); full = (count==DEPTH), both from registered count.
//  - Simultaneous read+write, same VC: both accepted, count unchanged. Empty VC:
//    the write is accepted but the read is not; no bypass, and err_udf is set.
//  - Simultaneous operations on different VCs are independent.
//  - Drops: a write to a full VC (without a same-VC read) or with wr_vc>=NUM_VC is
//    discarded and sets err_ovf. A read of an empty VC or with rd_vc>=NUM_VC is
//    ignored and sets err_udf. Error flags clear only on rst.
//  - Credits: credit_ret[v]=1 in the cycle after an accepted read of VC v, else 0.
//    At most one bit is set per cycle. Upstream initial credits = DEPTH per VC.
//  - Latency: write-to-visible on rd_flit/vc_nempty = 1 cycle.
//    Read-to-credit = 1 cycle.
//  - Reset mid-operation: contents are discarded immediately and no credit pulse
//    is emitted. Upstream resets its credit counters on the same rst.
// STRUCTURE
//  - noc_pkg: FLIT_W default, VC_W/PTR_W helper functions, NI_VC = NUM_VC-1
//    constant, and the flit typedef shared with the router and NI.
//  - Sub-module vc_fifo: single-VC circular FIFO (storage, head/tail, count,
//    full/empty), instantiated NUM_VC times in a generate loop.
//  - Top level: decode wr_vc/rd_vc into per-VC enables, mux the head flits into
//    rd_flit, register credit_ret and the sticky error flags.
// TESTING
//  - Reset: assert rst mid-cycle -> all outputs 0 immediately, and vc_count=0 after
//    release.
//  - Fill VC1 with 0x11..0x14 (DEPTH=4) -> vc_full[1]=1, vc_count[1]=4; then read 4
//    -> rd_flit=0x11,0x12,0x13,0x14 in order, 4 credit_ret[1] pulses, vc_nempty[1]=0.
//  - Full VC0: write 0xAA while reading the same VC -> both accepted, count stays 4,
//    err_ovf=0. Write 0xBB with no read -> dropped, err_ovf=1, head unchanged.
//  - Empty VC2: simultaneous write 0x5A and read -> count=1, rd_flit=0x5A next cycle,
//    err_udf=1, no credit pulse.
//  - Interleave writes to VC0/VC1/VC2 and reads of another VC in the same cycle ->
//    per-VC order preserved, counts independent; wrap tails 3x past DEPTH without
//    corruption.
//  - wr_vc=3 and rd_vc=3 with NUM_VC=3 -> no state change, err_ovf=1, err_udf=1,
//    rd_flit=0.

Source files
------------

// File: rtl/vc_buffer_bank_pkg.sv
// Shared NoC definitions: default widths, width helpers, NI channel index and
// the flit type used by the router, the network interface and the VC buffers.
package vc_buffer_bank_pkg;

  localparam int FLIT_W_DEF = 8;
  localparam int NUM_VC_DEF = 3;

  // The highest-numbered VC is reserved for the local network interface.
  localparam int NI_VC = NUM_VC_DEF - 1;

  typedef logic [FLIT_W_DEF-1:0] flit_t;

  // Width of a VC id; never narrower than one bit.
  function automatic int vc_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a FIFO pointer; never narrower than one bit.
  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/vc_buffer_bank_fifo.sv
// Single-VC circular FIFO with first-word fall-through head.
// The parent only asserts push_i when there is room (or a same-cycle pop)
// and only asserts pop_i when the FIFO holds at least one flit.
module vc_buffer_bank_fifo
  import vc_buffer_bank_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEPTH  = 4,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [FLIT_W-1:0] din_i,
  output logic [FLIT_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              nempty_o
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Pointer and occupancy next state; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    head_d  = head_q + PTR_W'(pop_i);
    tail_d  = tail_q + PTR_W'(push_i);
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  // Control state register; cleared asynchronously, contents are not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write at the tail; left unreset so it maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[tail_q] <= din_i;
    end
  end

  assign head_o   = mem_q[head_q];
  assign count_o  = count_q;
  assign full_o   = (count_q == FULL_CNT);
  assign nempty_o = (count_q != '0);

endmodule

// File: rtl/vc_buffer_bank.sv
// Per-input-port virtual-channel buffer bank.
// Handshake: a write is accepted on a clk edge when wr_en=1, wr_vc names a real
// VC and that VC has room (or is read in the same cycle); a read is accepted when
// rd_en=1, rd_vc names a real VC and that VC is non-empty. There is no backpressure
// signal: upstream tracks space with credits, one credit returned per accepted read.
module vc_buffer_bank
  import vc_buffer_bank_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int NUM_VC = NUM_VC_DEF,
  parameter int DEPTH  = 4,
  localparam int VC_W  = vc_w(NUM_VC),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [VC_W-1:0]         wr_vc,
  input  logic [FLIT_W-1:0]       wr_flit,
  input  logic                    rd_en,
  input  logic [VC_W-1:0]         rd_vc,
  output logic [FLIT_W-1:0]       rd_flit,
  output logic [NUM_VC-1:0]       vc_nempty,
  output logic [NUM_VC-1:0]       vc_full,
  output logic [NUM_VC*CNT_W-1:0] vc_count,
  output logic [NUM_VC-1:0]       credit_ret,
  output logic                    err_ovf,
  output logic                    err_udf
);

  // One extra bit so NUM_VC == 2**VC_W still compares correctly.
  localparam logic [VC_W:0] VC_LIMIT = (VC_W + 1)'(NUM_VC);

  logic              wr_in_range, rd_in_range;
  logic [NUM_VC-1:0] wr_acc, rd_acc;
  logic [NUM_VC-1:0] fifo_full, fifo_nempty;
  logic [FLIT_W-1:0] head [NUM_VC];
  logic [CNT_W-1:0]  cnt  [NUM_VC];

  logic [NUM_VC-1:0] credit_q, credit_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_udf_q, err_udf_d;

  assign wr_in_range = ({1'b0, wr_vc} < VC_LIMIT);
  assign rd_in_range = ({1'b0, rd_vc} < VC_LIMIT);

  // Decode requests into per-VC accepts; a full VC may take a write only if it is read in the same cycle.
  always_comb begin
    rd_acc = '0;
    wr_acc = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (rd_en && rd_in_range && (rd_vc == VC_W'(v)) && fifo_nempty[v]) begin
        rd_acc[v] = 1'b1;
      end
      if (wr_en && wr_in_range && (wr_vc == VC_W'(v)) && (!fifo_full[v] || rd_acc[v])) begin
        wr_acc[v] = 1'b1;
      end
    end
  end

  // Head-flit mux: zero for an empty or nonexistent VC, never a stale entry.
  always_comb begin
    rd_flit = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (rd_in_range && (rd_vc == VC_W'(v)) && fifo_nempty[v]) begin
        rd_flit = head[v];
      end
    end
  end

  // Credit and sticky error next state; a request that no VC accepted is a drop.
  always_comb begin
    credit_d  = rd_acc;
    err_ovf_d = err_ovf_q | (wr_en && (wr_acc == '0));
    err_udf_d = err_udf_q | (rd_en && (rd_acc == '0));
  end

  // Credit pulse and error flag registers; reset kills any in-flight credit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_q  <= '0;
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      credit_q  <= credit_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_buffer_bank_fifo #(
      .FLIT_W (FLIT_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_i   (wr_acc[v]),
      .pop_i    (rd_acc[v]),
      .din_i    (wr_flit),
      .head_o   (head[v]),
      .count_o  (cnt[v]),
      .full_o   (fifo_full[v]),
      .nempty_o (fifo_nempty[v])
    );
    assign vc_count[v*CNT_W +: CNT_W] = cnt[v];
  end

  assign vc_nempty  = fifo_nempty;
  assign vc_full    = fifo_full;
  assign credit_ret = credit_q;
  assign err_ovf    = err_ovf_q;
  assign err_udf    = err_udf_q;

endmodule
